alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single 8-bit ALU (control unit plus add/sub/mul/div datapath) among N independent requesters.
- Accepts valid/ready requests carrying op and operands, and picks one by round-robin.
- Sequences the ALU with a one-cycle start pulse, waits for ALU ready, then returns the result to the granted requester as a one-hot response pulse.
- Sits between client blocks (sequencer, test harness, DMA-like users) and the ALU top.

Parameters:
- N, 4: number of requesters (2..8).
- RES_W, 16: result width; covers 16-bit mul product, and div {remainder, quotient}.
- TIMEOUT_CYCLES, 64: WAIT-state watchdog limit; used only with ALU_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester accept; at most one bit high
- req_op  in  2*N  packed op per requester: 00 add, 01 sub, 10 mul, 11 div
- req_a  in  8*N  packed operand A
- req_b  in  8*N  packed operand B
- alu_start  out  1  one-cycle start to ALU control unit
- alu_op  out  2  latched op
- alu_a  out  8  latched operand A
- alu_b  out  8  latched operand B
- alu_ready  in  1  ALU completion, level; may assert in the same cycle as alu_start (add/sub)
- alu_result  in  RES_W  ALU result, valid while alu_ready=1
- rsp_valid  out  N  one-hot one-cycle response pulse
- rsp_result  out  RES_W  response data, held until next response
- rsp_err  out  1  timeout flag, qualified by rsp_valid; constant 0 without ALU_ARB_TIMEOUT_EN
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any state):
  - state=IDLE, rr pointer=0.
  - All outputs 0: req_ready, alu_start, alu_op/a/b, rsp_valid, rsp_result, rsp_err, busy.
  - An in-flight operation is abandoned with no response.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i], searching from ptr upward with wrap mod N.
  - req_ready[g]=1 combinationally; handshake completes this cycle.
  - Latch op/a/b[g] and g; go to ISSUE.
  - If no valid: stay in IDLE, req_ready=0.
- ISSUE:
  - alu_start=1 for exactly one cycle; alu_op/a/b are driven from latches and stay stable until the next grant.
  - If alu_ready=1 this cycle: capture alu_result and go to RESP. Else go to WAIT.
- WAIT: hold until alu_ready=1, then capture alu_result and go to RESP.
- RESP:
  - rsp_valid[g]=1 for one cycle; rsp_result=captured value.
  - ptr <= (g+1) mod N; go to IDLE.
- Latency: accept at cycle T; alu_start at T+1; earliest rsp_valid at T+2. Next accept earliest at T+3.
- No response backpressure: a requester must sample rsp_valid when it pulses.
- A requester dropping req_valid before its handshake is legal. Once accepted, the request always completes (or times out).
- Simultaneous requests: only one is granted. Others stay pending with req_ready=0.
- Pointer wrap: ptr=N-1 wraps to 0.
- alu_ready high in IDLE/RESP is ignored.
- Non-power-of-2 N: index arithmetic wraps explicitly at N.

Optional Feature:
- Macro ALU_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without alu_ready: go to RESP with rsp_err=1, rsp_result=0.
  - A late alu_ready is then ignored in IDLE.
- Undefined: no counter; WAIT is unbounded; rsp_err tied 0.

Decomposition:
- Shared package alu_pkg:
  - op codes OP_ADD/OP_SUB/OP_MUL/OP_DIV (2-bit)
  - arbiter state enum
  - RES_W default
- Sub-module rr_arbiter: combinational N-way round-robin pick.
  - Inputs: req vector, ptr.
  - Outputs: grant one-hot, grant index, any.
  - Unit-testable in isolation.

Test Plan:
- req0 add a=0x12 b=0x34, alu_ready same cycle as start -> req_ready[0] at T, alu_start T+1, rsp_valid=0001 at T+2, rsp_result=0x0046.
- req1 mul a=0x0F b=0x10, alu_ready 8 cycles after start, result 0x00F0 -> busy high throughout, rsp_valid=0010, rsp_result=0x00F0.
- req0..3 valid continuously from reset -> grant order 0,1,2,3,0,1; each granted once per 4 transactions.
- req3 and req0 valid together, ptr=3 -> grant 3 first, then 0 (wrap); ptr ends at 1.
- Reset pulse during WAIT of a div -> all outputs 0 next edge, no rsp_valid; a new req2 request is served with grant 2.
- ALU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64, alu_ready never asserts -> rsp_valid after 64 WAIT cycles, rsp_err=1, rsp_result=0; next request serviced normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the logic that shares it:
// op codes, the arbiter state encoding and the default result width.
package alu_pkg;

  // Result width: 16-bit mul product, or div {remainder, quotient}.
  localparam int RES_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr.sv
// Combinational N-way round-robin pick. The search starts at ptr_i and
// walks upward, wrapping explicitly at N so non-power-of-2 N works.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  // First requester at or after the pointer wins.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search loop, otherwise
    // the "no request" path would leave them unassigned and infer latches.
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_idx_o  = IDX_W'(idx);
        grant_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 8-bit ALU among N requesters. Round-robin grant in IDLE,
// one-cycle alu_start in ISSUE, wait for alu_ready, then a one-hot
// response pulse to the granted requester.
// Optional build macro: ALU_ARB_TIMEOUT_EN adds a WAIT-state watchdog that
// answers with rsp_err=1, rsp_result=0 after TIMEOUT_CYCLES WAIT cycles.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int N              = 4,
  parameter int RES_W          = RES_W_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [2*N-1:0]   req_op,
  input  logic [8*N-1:0]   req_a,
  input  logic [8*N-1:0]   req_b,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  input  logic             alu_ready,
  input  logic [RES_W-1:0] alu_result,
  output logic [N-1:0]     rsp_valid,
  output logic [RES_W-1:0] rsp_result,
  output logic             rsp_err,
  output logic             busy
);

  localparam int IDX_W = $clog2(N);

  arb_state_e       state_q;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] g_q;
  alu_op_e          op_q;
  logic [7:0]       a_q, b_q;
  logic             start_q;
  logic [N-1:0]     rsp_valid_q;
  logic [RES_W-1:0] rsp_result_q;

  logic [N-1:0]     gnt_onehot;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [N-1:0]     g_onehot;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             rsp_err_q;
`endif

  rr_arbiter #(.N(N)) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (gnt_onehot),
    .grant_idx_o (gnt_idx),
    .any_o       (gnt_any)
  );

  // Pointer moves just past the last served requester, wrapping at N.
  assign ptr_d    = (g_q == IDX_W'(N - 1)) ? '0 : g_q + 1'b1;
  assign g_onehot = N'(1) << g_q;

  // Main sequencer: grant, issue, wait, respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      g_q          <= '0;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      start_q      <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // state as it was at the clock edge regardless of statement order.
      start_q     <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_any) begin
            g_q     <= gnt_idx;
            op_q    <= alu_op_e'(req_op[2*gnt_idx +: 2]);
            a_q     <= req_a[8*gnt_idx +: 8];
            b_q     <= req_b[8*gnt_idx +: 8];
            start_q <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (alu_ready) begin
            rsp_result_q <= alu_result;
            rsp_valid_q  <= g_onehot;
`ifdef ALU_ARB_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
`endif
            state_q      <= ST_RESP;
          end else begin
`ifdef ALU_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
            state_q      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (alu_ready) begin
            rsp_result_q <= alu_result;
            rsp_valid_q  <= g_onehot;
`ifdef ALU_ARB_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
`endif
            state_q      <= ST_RESP;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          // The WAIT cycle holding count TIMEOUT_CYCLES-1 is the last one.
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_result_q <= '0;
            rsp_valid_q  <= g_onehot;
            rsp_err_q    <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          ptr_q   <= ptr_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Accept is combinational in IDLE; forced low while reset is asserted.
  assign req_ready  = (state_q == ST_IDLE && !reset) ? gnt_onehot : '0;
  assign alu_start  = start_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef ALU_ARB_TIMEOUT_EN
  assign rsp_err    = rsp_err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table-driven single transactions, hand-written
// round-robin / reset / timeout sequences, and a randomized phase checked by
// a transaction-level round-robin model with an expected-response queue.
module tb_alu_share_arbiter;

  localparam int N     = 4;
  localparam int RES_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [2*N-1:0]   req_op;
  logic [8*N-1:0]   req_a;
  logic [8*N-1:0]   req_b;
  logic             alu_start;
  logic [1:0]       alu_op;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic             alu_ready;
  logic [RES_W-1:0] alu_result;
  logic [N-1:0]     rsp_valid;
  logic [RES_W-1:0] rsp_result;
  logic             rsp_err;
  logic             busy;

  alu_share_arbiter #(.N(N), .RES_W(RES_W), .TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ready  (alu_ready),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU arithmetic.
  function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return 16'(a) + 16'(b);
      2'b01:   return {8'h00, 8'(a - b)};
      2'b10:   return 16'(a) * 16'(b);
      default: return (b == 8'h00) ? 16'hFFFF : {8'(a % b), 8'(a / b)};
    endcase
  endfunction

  // Round-robin rule: first valid index at or after p, modulo N.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // ---------------- ALU responder ----------------
  // alu_lat < 0 means the ALU never answers; 0 means same cycle as start.
  int          alu_lat = 0;
  int          alu_left = 0;
  logic        alu_pend = 1'b0;
  logic [15:0] alu_res = '0;

  initial begin
    alu_ready  = 1'b0;
    alu_result = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        alu_pend  = 1'b0;
        alu_ready = 1'b0;
      end else begin
        if (alu_ready) begin
          alu_ready = 1'b0;
          alu_pend  = 1'b0;
        end
        if (alu_start) begin
          alu_pend = 1'b1;
          alu_left = alu_lat;
          alu_res  = alu_fn(alu_op, alu_a, alu_b);
        end
        if (alu_pend) begin
          if (alu_left == 0) begin
            alu_ready  = 1'b1;
            alu_result = alu_res;
          end else if (alu_left > 0) begin
            alu_left--;
          end
        end
      end
    end
  end

  // ---------------- transaction-level model / monitor ----------------
  typedef struct {
    int          idx;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t         exp_q[$];
  int           gnt_log[$];
  int           acc_t[$];
  int           mdl_ptr = 0;
  int           cyc = 0;
  logic [N-1:0] acc = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      mdl_ptr = 0;
      exp_q.delete();
    end else begin
      check("mon_busy", busy, (exp_q.size() != 0));
      if (exp_q.size() == 0 && req_valid != '0) begin
        int   g;
        exp_t e;
        g = rr_pick(req_valid, mdl_ptr);
        check("mon_grant", req_ready, 32'(1) << g);
        e.idx = g;
        e.err = (alu_lat < 0);
        e.res = e.err ? 16'h0000 : alu_fn(req_op[2*g +: 2], req_a[8*g +: 8], req_b[8*g +: 8]);
        exp_q.push_back(e);
        gnt_log.push_back(g);
        acc_t.push_back(cyc);
        acc[g]  = 1'b1;
        mdl_ptr = (g + 1) % N;
      end else begin
        check("mon_no_ready", req_ready, 0);
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected_rsp", rsp_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("mon_rsp_valid", rsp_valid, 32'(1) << e.idx);
          check("mon_rsp_result", rsp_result, e.res);
          check("mon_rsp_err", rsp_err, e.err);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[2*i +: 2] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_valid[i]     = 1'b1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #1;
    check("rst_outs", {req_ready, alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_err, busy}, 0);
    check("rst_result", rsp_result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic drain;
    int guard;
    guard = 0;
    req_valid = '0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_done", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction with exact timing checks.
  task automatic run_txn(input logic [N-1:0] mask, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input int lat, input logic [N-1:0] exp_gnt,
                         input logic [15:0] exp_res);
    int n;
    @(posedge clk);
    #1;
    alu_lat = lat;
    for (int i = 0; i < N; i++)
      if (mask[i]) set_req(i, op, a, b);
    @(negedge clk);
    check("txn_ready", req_ready, exp_gnt);
    check("txn_idle_busy", busy, 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("txn_start", alu_start, 1);
    check("txn_operands", {alu_op, alu_a, alu_b}, {op, a, b});
    n = 0;
    while (rsp_valid == '0 && n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid == '0) check("txn_busy", busy, 1);
    end
    check("txn_latency", n, lat + 1);
    check("txn_rsp_valid", rsp_valid, exp_gnt);
    check("txn_rsp_result", rsp_result, exp_res);
    check("txn_rsp_err", rsp_err, 0);
    @(negedge clk);
    check("txn_pulse_end", rsp_valid, 0);
    check("txn_idle_again", busy, 0);
    check("txn_result_held", rsp_result, exp_res);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [N-1:0] mask;
    logic [1:0]   op;
    logic [7:0]   a;
    logic [7:0]   b;
    int           lat;
    logic [N-1:0] gnt;
    logic [15:0]  res;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;

    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;

    // Pointer sequence from reset: 0 -> 1 -> 2 -> 3 -> 0 -> 1 -> 3 -> 2.
    vecs[0] = '{4'b0001, 2'b00, 8'h12, 8'h34, 0, 4'b0001, 16'h0046};
    vecs[1] = '{4'b0010, 2'b10, 8'h0F, 8'h10, 8, 4'b0010, 16'h00F0};
    vecs[2] = '{4'b1111, 2'b01, 8'h50, 8'h20, 2, 4'b0100, 16'h0030};
    vecs[3] = '{4'b1001, 2'b11, 8'h64, 8'h07, 1, 4'b1000, 16'h020E};
    vecs[4] = '{4'b1001, 2'b00, 8'hFF, 8'hFF, 0, 4'b0001, 16'h01FE};
    vecs[5] = '{4'b0100, 2'b11, 8'h10, 8'h00, 3, 4'b0100, 16'hFFFF};
    vecs[6] = '{4'b0110, 2'b01, 8'h00, 8'h01, 0, 4'b0010, 16'h00FF};

    do_reset();
    for (int v = 0; v < 7; v++)
      run_txn(vecs[v].mask, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].lat, vecs[v].gnt, vecs[v].res);

    // All four requesters valid continuously from reset.
    do_reset();
    gnt_log.delete();
    acc_t.delete();
    acc = '0;
    @(posedge clk);
    #1;
    alu_lat = 0;
    for (int i = 0; i < N; i++) set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    guard = 0;
    while (gnt_log.size() < 8 && guard < 60) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (acc[i]) begin
          acc[i] = 1'b0;
          set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end
      guard++;
    end
    check("rr_count", (gnt_log.size() >= 8), 1);
    if (gnt_log.size() >= 8) begin
      for (int k = 0; k < 8; k++) check("rr_order", gnt_log[k], k % N);
      for (int k = 1; k < 8; k++) check("rr_spacing", acc_t[k] - acc_t[k-1], 3);
    end
    drain();

    // Randomized traffic against the model.
    acc = '0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      alu_lat = $urandom_range(0, 4);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          acc[i]       = 1'b0;
          req_valid[i] = 1'b0;
        end
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    drain();

    // Reset while a div is stuck in WAIT.
    do_reset();
    run_txn(4'b0001, 2'b00, 8'h01, 8'h02, 0, 4'b0001, 16'h0003);
    @(posedge clk);
    #1;
    alu_lat = -1;
    set_req(1, 2'b11, 8'h64, 8'h07);
    @(negedge clk);
    check("rstw_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rstw_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rstw_async", {req_ready, alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_err, busy}, 0);
    @(posedge clk);
    #1;
    check("rstw_outs", {req_ready, alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_err, busy}, 0);
    check("rstw_result", rsp_result, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != '0) n++;
    end
    check("rstw_no_rsp", n, 0);
    run_txn(4'b0100, 2'b00, 8'h05, 8'h06, 0, 4'b0100, 16'h000B);

`ifdef ALU_ARB_TIMEOUT_EN
    // ALU never answers: 64 WAIT cycles, then an error response.
    do_reset();
    @(posedge clk);
    #1;
    alu_lat = -1;
    set_req(0, 2'b00, 8'h03, 8'h04);
    @(negedge clk);
    check("to_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("to_start", alu_start, 1);
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", n, 65);
    check("to_rsp_valid", rsp_valid, 4'b0001);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_result", rsp_result, 0);
    run_txn(4'b0010, 2'b00, 8'h01, 8'h01, 0, 4'b0010, 16'h0002);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
